// File: rtl/ultraman_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ultraman_mem_arbiter_if
// Brief    : core-side instruction/data memory bus between CPU and the arbiter.
// Revision : 1.0
// ============================================================================
interface ultraman_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_rvalid;

  logic        d_wren;
  logic        d_rden;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_rvalid;

  logic        hold;

  modport master (
    output i_req, i_addr, d_wren, d_rden, d_addr, d_wdata, d_wstrb,
    input  i_rdata, i_rvalid, d_rdata, d_rvalid, hold
  );

  modport slave (
    input  i_req, i_addr, d_wren, d_rden, d_addr, d_wdata, d_wstrb,
    output i_rdata, i_rvalid, d_rdata, d_rvalid, hold
  );
endinterface
`default_nettype wire

// File: rtl/ultraman_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ultraman_mem_arbiter
// Brief    : instruction/data arbiter for one single-port SRAM with one-entry
//            pending buffers per side and in-order read-return tracking.
// Revision : 1.0
// ============================================================================
module ultraman_mem_arbiter #(
  parameter int RD_LATENCY = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  ultraman_mem_arbiter_if.slave bus,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [29:0]           sram_addr,
  output logic [31:0]           sram_wdata,
  output logic [3:0]            sram_wstrb,
  input  logic [31:0]           sram_rdata,
  output logic                  overflow
);

  localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

  // Pending buffers
  logic                  r_ip_valid;
  logic [29:0]           r_ip_addr;
  logic                  r_dp_valid;
  logic [29:0]           r_dp_addr;
  logic [31:0]           r_dp_wdata;
  logic [3:0]            r_dp_wstrb;
  logic                  r_dp_we;

  logic [3:0]            r_wait_cnt;
  logic                  r_overflow;

  logic [RD_LATENCY-1:0] r_trk_vld;
  logic [RD_LATENCY-1:0] r_trk_src;
  logic [31:0]           r_i_rdata;
  logic [31:0]           r_d_rdata;

  logic                  w_d_live;
  logic                  w_i_cand;
  logic [29:0]           w_i_addr;
  logic                  w_d_cand;
  logic [29:0]           w_d_addr;
  logic [31:0]           w_d_wdata;
  logic [3:0]            w_d_wstrb;
  logic                  w_d_we;
  logic                  w_i_starved;
  logic                  w_gnt_i;
  logic                  w_gnt_d;
  logic                  w_ip_load;
  logic                  w_ip_clear;
  logic                  w_dp_load;
  logic                  w_dp_clear;
  logic                  w_i_drop;
  logic                  w_d_drop;
  logic                  w_rd_gnt;
  logic                  w_tail_vld;
  logic                  w_i_ret;
  logic                  w_d_ret;
  logic                  w_unused_addr_lsbs;

  // Byte-offset bits never reach the word-addressed SRAM.
  assign w_unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  // A write wins when both data strobes are high.
  assign w_d_live  = bus.d_wren | bus.d_rden;

  assign w_i_cand  = r_ip_valid | bus.i_req;
  assign w_i_addr  = r_ip_valid ? r_ip_addr : bus.i_addr[31:2];

  assign w_d_cand  = r_dp_valid | w_d_live;
  assign w_d_addr  = r_dp_valid ? r_dp_addr  : bus.d_addr[31:2];
  assign w_d_wdata = r_dp_valid ? r_dp_wdata : bus.d_wdata;
  assign w_d_wstrb = r_dp_valid ? r_dp_wstrb : bus.d_wstrb;
  assign w_d_we    = r_dp_valid ? r_dp_we    : bus.d_wren;

  assign w_i_starved = (r_wait_cnt == c_MAX_WAIT);

  // resetn gating keeps the SRAM command quiet while reset is asserted.
  assign w_gnt_d = resetn & w_d_cand & ~(w_i_cand & w_i_starved);
  assign w_gnt_i = resetn & w_i_cand & ~w_gnt_d;

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wstrb = '0;
    if (w_gnt_d) begin
      sram_en   = 1'b1;
      sram_we   = w_d_we;
      sram_addr = w_d_addr;
      if (w_d_we) begin
        sram_wdata = w_d_wdata;
        sram_wstrb = w_d_wstrb;
      end
    end else if (w_gnt_i) begin
      sram_en   = 1'b1;
      sram_addr = w_i_addr;
    end
  end

  // A live request lands in the buffer if the buffer is free and the request
  // loses, or if the buffer's current occupant is being granted this cycle.
  assign w_ip_load  = bus.i_req & (r_ip_valid ? w_gnt_i : ~w_gnt_i);
  assign w_ip_clear = r_ip_valid & w_gnt_i & ~bus.i_req;
  assign w_i_drop   = r_ip_valid & ~w_gnt_i & bus.i_req;

  assign w_dp_load  = w_d_live & (r_dp_valid ? w_gnt_d : ~w_gnt_d);
  assign w_dp_clear = r_dp_valid & w_gnt_d & ~w_d_live;
  assign w_d_drop   = r_dp_valid & ~w_gnt_d & w_d_live;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ip_valid <= 1'b0;
      r_ip_addr  <= '0;
    end else if (w_ip_load) begin
      r_ip_valid <= 1'b1;
      r_ip_addr  <= bus.i_addr[31:2];
    end else if (w_ip_clear) begin
      r_ip_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dp_valid <= 1'b0;
      r_dp_addr  <= '0;
      r_dp_wdata <= '0;
      r_dp_wstrb <= '0;
      r_dp_we    <= 1'b0;
    end else if (w_dp_load) begin
      r_dp_valid <= 1'b1;
      r_dp_addr  <= bus.d_addr[31:2];
      r_dp_wdata <= bus.d_wdata;
      r_dp_wstrb <= bus.d_wstrb;
      r_dp_we    <= bus.d_wren;
    end else if (w_dp_clear) begin
      r_dp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_gnt_i) begin
        r_wait_cnt <= '0;
      end else if (w_i_cand && !w_i_starved) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      if (w_i_drop || w_d_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Read-return tracker: src=1 marks a data-side read.
  assign w_rd_gnt = sram_en & ~sram_we;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_trk_vld <= '0;
      r_trk_src <= '0;
    end else begin
      r_trk_vld[0] <= w_rd_gnt;
      r_trk_src[0] <= w_gnt_d;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_trk_vld[k] <= r_trk_vld[k-1];
        r_trk_src[k] <= r_trk_src[k-1];
      end
    end
  end

  assign w_tail_vld = r_trk_vld[RD_LATENCY-1];
  assign w_i_ret    = w_tail_vld & ~r_trk_src[RD_LATENCY-1];
  assign w_d_ret    = w_tail_vld &  r_trk_src[RD_LATENCY-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_i_ret) r_i_rdata <= sram_rdata;
      if (w_d_ret) r_d_rdata <= sram_rdata;
    end
  end

  // The return cycle forwards the SRAM word; afterwards the register holds it.
  assign bus.i_rvalid = w_i_ret;
  assign bus.i_rdata  = w_i_ret ? sram_rdata : r_i_rdata;
  assign bus.d_rvalid = w_d_ret;
  assign bus.d_rdata  = w_d_ret ? sram_rdata : r_d_rdata;

  assign bus.hold = r_ip_valid | r_dp_valid;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
